stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Control front-end for the two-digit BCD seconds counter on the DE1 board. It synchronises and debounces two raw pushbuttons and runs a start/pause/clear state machine. It divides CLOCK_50 down to a one-cycle tick strobe, and its tick and clear outputs drive the counter's increment enable and reset directly.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
TICK_HZ, 1, tick strobe rate in Hz; DIV = CLK_HZ/TICK_HZ, with DIV >= 2
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a key level change (20 ms), >= 2

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low
key_start_n  input  1  raw start/pause pushbutton, active-low, asynchronous to clock
key_clear_n  input  1  raw clear pushbutton, active-low, asynchronous to clock
sw_enable  input  1  slide-switch gate; 0 freezes the prescaler
tick  output  1  one-cycle count strobe to the downstream BCD counter
run  output  1  high in RUNNING state
clear  output  1  one-cycle pulse; downstream counter zeroes its digits
state  output  2  00 IDLE, 01 RUNNING, 10 PAUSED

Behaviour:
- Reset (reset==0 at a clock edge) sets:
  - synchroniser FFs to 1;
  - debounced levels to 1 (released);
  - debounce counters and prescaler to 0;
  - state to IDLE;
  - tick, clear and run to 0.
- Reset overrides all other activity, including mid-debounce and mid-count.
- Per key, input conditioning:
  - 2-FF synchroniser feeds a debounce counter.
  - Each cycle the sync output equals the debounced level, the counter clears to 0.
  - Each cycle it differs, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the new value and the counter clears.
- Press event: a debounced 1->0 transition. It produces an internal one-cycle pulse on the cycle after the debounced level changes.
  - Fixed latency from the first edge sampling raw low (stable) to the FSM acting on the press: L = DEBOUNCE_CYCLES + 3 edges.
  - Release events produce no action.
  - A held key produces exactly one press event.
- FSM transitions on press events:
  - start: IDLE->RUNNING, RUNNING->PAUSED, PAUSED->RUNNING.
  - clear (any state): state goes to IDLE and the prescaler goes to 0. The clear output is asserted for exactly one cycle, registered, in the same cycle the state changes.
  - start and clear events in the same cycle: clear wins; result is IDLE with one clear pulse.
- Prescaler: width $clog2(DIV), range 0..DIV-1.
  - Increments only when state==RUNNING and sw_enable==1. Otherwise it holds; in IDLE it is held at 0.
  - At DIV-1 it wraps to 0.
  - tick is registered and high for the one cycle following the wrap edge, giving exactly one tick per DIV enabled cycles.
  - The first tick after IDLE->RUNNING occurs DIV enabled cycles after run rises.
  - PAUSED retains the prescaler value, so resuming completes the partial period; partial periods are not lost.
- run and state are registered FSM outputs. run==1 iff state==RUNNING.
- tick and clear are never high in the same cycle. On a clear event, a pending tick is suppressed.
- sw_enable is a level input and is used unsynchronised; the switch is treated as quasi-static.

Test Plan:
(all with CLK_HZ=20, TICK_HZ=1 so DIV=20, and DEBOUNCE_CYCLES=4)
1. Hold reset low 3 cycles with keys released, then release reset -> tick=0, clear=0, run=0, state=00; all remain unchanged for 100 cycles.
2. Drive key_start_n low cleanly and hold it -> state=01 and run=1 exactly 7 edges after the first low sample. Ticks follow at 20, 40 and 60 cycles after run rises, each exactly 1 cycle wide. Holding the key causes no further state change.
3. Bounce: key_start_n low for 3 cycles, high 1 cycle, low 3 cycles, then high -> no press event; state stays 00.
4. In RUNNING, press start when the prescaler reads 7 -> state=10 and the prescaler holds 7 while PAUSED. Press start again -> state=01, and the next tick arrives 13 enabled cycles after resume.
5. In RUNNING, press start and clear with identical timing -> state=00, exactly one clear pulse, prescaler=0, no tick in the clear cycle.
6. In RUNNING, drop sw_enable for 50 cycles mid-period -> no ticks, run stays 1, prescaler frozen. On restoring sw_enable, the tick spacing sums to exactly 20 enabled cycles.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control front-end for the two-digit BCD seconds counter.
// Conditions two raw pushbuttons (2-FF synchroniser + debounce), runs the
// start/pause/clear state machine and divides the system clock down to a
// one-cycle count strobe for the downstream counter.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-low
//   key_start_n  raw start/pause pushbutton, active-low, asynchronous
//   key_clear_n  raw clear pushbutton, active-low, asynchronous
//   sw_enable    slide-switch gate; 0 freezes the prescaler
//   tick         one-cycle count strobe to the BCD counter
//   run          high while RUNNING
//   clear        one-cycle pulse that zeroes the BCD counter
//   state        00 IDLE, 01 RUNNING, 10 PAUSED
module stopwatch_ctrl #(
    parameter int CLK_HZ          = 50000000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_start_n,
    input  logic       key_clear_n,
    input  logic       sw_enable,
    output logic       tick,
    output logic       run,
    output logic       clear,
    output logic [1:0] state
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int DW  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0] DEBOUNCE_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10
    } state_t;

    // Bit 0 is the start key, bit 1 the clear key throughout.
    logic [1:0]    key_raw;
    logic [1:0]    sync_meta;
    logic [1:0]    sync_out;
    logic [1:0]    key_level;
    logic [1:0]    key_level_d;
    logic [DW-1:0] debounce_count [2];
    logic [1:0]    press;
    logic          start_press;
    logic          clear_press;

    state_t        state_q;
    state_t        state_next;

    logic [PW-1:0] prescale;
    logic          count_en;
    logic          wrap;

    assign key_raw = {key_clear_n, key_start_n};

    // Two-stage synchroniser; resets to the released level so no
    // spurious press is seen when reset is lifted.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_meta <= 2'b11;
            sync_out  <= 2'b11;
        end else begin
            sync_meta <= key_raw;
            sync_out  <= sync_meta;
        end
    end

    // Debounce: the accepted level only follows the synchronised key once
    // it has disagreed for DEBOUNCE_CYCLES consecutive cycles; any cycle of
    // agreement restarts the count, so bounces never get through.
    always_ff @(posedge clock) begin
        if (!reset) begin
            key_level   <= 2'b11;
            key_level_d <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                debounce_count[k] <= '0;
            end
        end else begin
            key_level_d <= key_level;
            for (int k = 0; k < 2; k++) begin
                if (sync_out[k] == key_level[k]) begin
                    debounce_count[k] <= '0;
                end else if (debounce_count[k] == DEBOUNCE_LAST) begin
                    key_level[k]      <= sync_out[k];
                    debounce_count[k] <= '0;
                end else begin
                    debounce_count[k] <= debounce_count[k] + 1'b1;
                end
            end
        end
    end

    // A press is the falling edge of the debounced level, seen for one
    // cycle right after the level changes; releases are ignored.
    assign press       = key_level_d & ~key_level;
    assign start_press = press[0];
    assign clear_press = press[1];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Clear has priority over start when both land in the same cycle.
    always_comb begin
        state_next = state_q;
        if (clear_press) begin
            state_next = IDLE;
        end else if (start_press) begin
            case (state_q)
                IDLE:    state_next = RUNNING;
                RUNNING: state_next = PAUSED;
                PAUSED:  state_next = RUNNING;
                default: state_next = IDLE;
            endcase
        end
    end

    // run and clear are registered so they change together with state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            run   <= 1'b0;
            clear <= 1'b0;
        end else begin
            run   <= (state_next == RUNNING);
            clear <= clear_press;
        end
    end

    // The prescaler only advances while RUNNING with the switch up. Masking
    // with clear_press keeps a tick out of the clear cycle; PAUSED simply
    // holds the count so the interrupted period is completed on resume.
    assign count_en = (state_q == RUNNING) && sw_enable && !clear_press;
    assign wrap     = count_en && (prescale == PRESCALE_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            prescale <= '0;
            tick     <= 1'b0;
        end else begin
            tick <= wrap;
            if (clear_press || wrap) begin
                prescale <= '0;
            end else if (count_en) begin
                prescale <= prescale + 1'b1;
            end
        end
    end

    assign state = state_q;

endmodule
